pippo_muldiv: RTL and testbench
===============================

Name: pippo_muldiv

Overview: Iterative multiply/divide unit for the pippo RISC-V execute stage. It implements the M-extension ops alongside the combinational ALU, generalised to WIDTH (32 or 64) with RV64 word (W) variants. It takes one operation at a time over a valid/ready handshake and holds the result until the writeback stage consumes it.

Parameters:
WIDTH, 64, operand/result width; legal values are 32 or 64.
CNT_W, 7, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept an op; high only in IDLE.
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
word  input  1  W variant (32-bit op); ignored when WIDTH=32.
bus_a  input  WIDTH  rs1 (multiplicand / dividend).
bus_b  input  WIDTH  rs2 (multiplier / divisor).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  registered result.
busy  output  1  state != IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high. On rst: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1. Reset mid-operation aborts with no output.
- Effective width N = (word && WIDTH==64) ? 32 : WIDTH.
- W mode: operands are taken from bits [31:0], sign- or zero-extended per op signedness. The 32-bit result is sign-extended to WIDTH. MULH/MULHSU/MULHU with word=1 are illegal; the unit returns 0.
- Signedness: MUL, MULH, DIV and REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. The rest are unsigned. Signed ops use absolute values internally and negate at the end.
- States are IDLE, CALC, DONE.
- IDLE: on in_valid, latch the operands, op and word.
  - Divide by zero: go to DONE next cycle. Quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): go to DONE next cycle. Quotient = dividend; remainder = 0.
  - Otherwise go to CALC with cnt=0.
- CALC, multiply: radix-2 shift-add into a 2N-bit accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, with an N+1-bit partial remainder.
- CALC ends after N cycles (cnt==N-1). On that edge, sign correction and result selection are applied and registered into result; out_valid is set.
  - MUL returns the low N bits of the product; the MULH* ops return the high N bits.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- DONE: out_valid=1 and result is held stable while out_ready=0. out_valid && out_ready moves to IDLE, clears out_valid, and keeps result.
- Latency: request accepted at edge t gives out_valid at t+N+1 for normal ops and t+1 for the special divide cases. in_ready is low from t+1 until the edge after the output handshake. The minimum initiation interval is therefore N+2 cycles.
- in_valid while not in_ready is ignored; the requester must hold it.
- Operand changes after acceptance have no effect.

Optional Feature:
PIPPO_MULDIV_KILL_EN
- Defined: adds input port kill (1 bit). kill=1 in CALC or DONE returns to IDLE next cycle, clears out_valid and discards the op. kill in IDLE blocks acceptance that cycle. kill has priority over the out handshake.
- Undefined: no port; an op can only be aborted by rst.

Decomposition:
- def_pippo.v holds the MULDIVOP_* op-code macros, MULDIVOP_WIDTH, and the state encodings.
- pippo_muldiv holds the FSM, handshake, special-case detection and sign fix.
- Sub-module pippo_muldiv_iter holds the shared accumulator/remainder shift datapath: one step per enable, with inputs mode (mul/div) and N.

Test Plan:
- WIDTH=32, MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 33 cycles after accept.
- WIDTH=32, MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- WIDTH=32, DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after 1 cycle. DIVU 9/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
- WIDTH=32, REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- WIDTH=64, DIVW a=0x12345678_FFFFFFF8, b=2 -> 0xFFFFFFFF_FFFFFFFC, latency 33. MUL 64-bit 2^40 × 3 -> 0x0000_0300_0000_0000, latency 65.
- Backpressure: hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0. rst asserted mid-CALC -> out_valid=0 and in_ready=1 next cycle.

Source files
------------

// File: rtl/pippo_muldiv_pkg.sv
// Shared types and helpers for the pippo multiply/divide unit.
// Op-code encoding, FSM states and the iterative datapath mode live here so
// the top level and the iteration datapath agree on them.
package pippo_muldiv_pkg;

    localparam int MULDIVOP_WIDTH = 3;

    typedef enum logic [MULDIVOP_WIDTH-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    function automatic logic op_is_div(input muldiv_op_e o);
        return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    function automatic logic op_is_mulh(input muldiv_op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_MULHU);
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
               (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic iter_mode_e op_mode(input muldiv_op_e o);
        return op_is_div(o) ? MODE_DIV : MODE_MUL;
    endfunction

endpackage

// File: rtl/pippo_muldiv_iter.sv
// Iterative datapath shared by multiply and divide, one step per enable.
// Multiply: shift-add, the multiplicand walks left and the multiplier right.
// Divide: restoring division; the accumulator holds the partial remainder and
// the multiplier register shifts the dividend out and the quotient in.
// Outputs are the post-step values so the caller can register the final
// result on the same edge as the last step.
module pippo_muldiv_iter
    import pippo_muldiv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  iter_mode_e         mode,
    input  logic [CNT_W-1:0]   n,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     part_rem;
    logic [WIDTH:0]     divisor;
    logic               take;

    // Next-state: load fresh operands, or advance one mul/div step.
    // The dividend is pre-aligned so its top bit always sits at WIDTH-1.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        part_rem = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        divisor  = mcand_q[WIDTH:0];
        take     = (part_rem >= divisor);
        if (load) begin
            acc_d = '0;
            if (mode == MODE_DIV) begin
                mcand_d  = {{WIDTH{1'b0}}, op_b};
                mplier_d = op_a << (CNT_W'(WIDTH) - n);
            end else begin
                mcand_d  = {{WIDTH{1'b0}}, op_a};
                mplier_d = op_b;
            end
        end else if (step) begin
            if (mode == MODE_DIV) begin
                acc_d    = {{(WIDTH-1){1'b0}}, (take ? (part_rem - divisor) : part_rem)};
                mplier_d = {mplier_q[WIDTH-2:0], take};
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign prod = acc_d;
    assign quo  = mplier_d;
    assign rem  = acc_d[WIDTH-1:0];

endmodule

// File: rtl/pippo_muldiv.sv
// pippo M-extension multiply/divide unit: FSM, handshakes, special-case
// detection and sign correction around the iterative datapath.
// Optional macro PIPPO_MULDIV_KILL_EN adds a 'kill' input that aborts the
// current operation and blocks acceptance while asserted.
module pippo_muldiv
    import pippo_muldiv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef PIPPO_MULDIV_KILL_EN
    input  logic                      kill,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MULDIVOP_WIDTH-1:0] op,
    input  logic                      word,
    input  logic [WIDTH-1:0]          bus_a,
    input  logic [WIDTH-1:0]          bus_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          result,
    output logic                      busy
);

    localparam int SH = WIDTH - 32;
    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32);

    // Reduce a value to its low 32 bits, sign- or zero-extended to WIDTH.
    function automatic logic [WIDTH-1:0] narrow(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] up;
        up = v << SH;
        if (sgn) begin
            return WIDTH'($signed(up) >>> SH);
        end
        return up >> SH;
    endfunction

    logic kill_w;
`ifdef PIPPO_MULDIV_KILL_EN
    assign kill_w = kill;
`else
    assign kill_w = 1'b0;
`endif

    muldiv_state_e    state_q, state_d;
    muldiv_op_e       op_q, op_d, op_in;
    logic             word_q, word_d, word_in;
    logic             sa_q, sa_d, sa_in;
    logic             sb_q, sb_d, sb_in;
    logic [CNT_W-1:0] cnt_q, cnt_d, n_in, n_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;
    logic [WIDTH-1:0] special_raw, special_res;
    logic             div_zero, div_ovf, bad_word, special;
    logic             accept, last;

    logic [2*WIDTH-1:0] it_prod, prod_fix;
    logic [WIDTH-1:0]   it_quo, it_rem, quo_fix, rem_fix, calc_raw, calc_res;
    iter_mode_e         it_mode;

    // Decode the incoming request: effective width, extended operands,
    // magnitudes and the divide special cases that bypass iteration.
    always_comb begin
        op_in   = muldiv_op_e'(op);
        word_in = (WIDTH == 64) && word;
        n_in    = word_in ? N_WORD : N_FULL;
        a_ext   = word_in ? narrow(bus_a, op_signed_a(op_in)) : bus_a;
        b_ext   = word_in ? narrow(bus_b, op_signed_b(op_in)) : bus_b;
        sa_in   = op_signed_a(op_in) && a_ext[WIDTH-1];
        sb_in   = op_signed_b(op_in) && b_ext[WIDTH-1];
        mag_a   = sa_in ? -a_ext : a_ext;
        mag_b   = sb_in ? -b_ext : b_ext;
        min_neg = word_in ? narrow(WIDTH'(32'h8000_0000), 1'b1)
                          : {1'b1, {(WIDTH-1){1'b0}}};
        div_zero = op_is_div(op_in) && (b_ext == '0);
        div_ovf  = op_is_div(op_in) && op_signed_b(op_in) &&
                   (a_ext == min_neg) && (b_ext == '1);
        bad_word = word_in && op_is_mulh(op_in);
        special  = div_zero || div_ovf || bad_word;
        if (bad_word) begin
            special_raw = '0;
        end else if (div_zero) begin
            special_raw = op_is_rem(op_in) ? a_ext : '1;
        end else begin
            special_raw = op_is_rem(op_in) ? '0 : a_ext;
        end
        special_res = word_in ? narrow(special_raw, 1'b1) : special_raw;
    end

    // Sign correction and result selection applied to the final step.
    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -it_prod : it_prod;
        quo_fix  = (sa_q ^ sb_q) ? -it_quo : it_quo;
        rem_fix  = sa_q ? -it_rem : it_rem;
        if (op_is_div(op_q)) begin
            calc_raw = op_is_rem(op_q) ? rem_fix : quo_fix;
        end else begin
            calc_raw = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
        calc_res = word_q ? narrow(calc_raw, 1'b1) : calc_raw;
    end

    assign accept  = (state_q == ST_IDLE) && in_valid && !kill_w;
    assign n_q     = word_q ? N_WORD : N_FULL;
    assign last    = (cnt_q == (n_q - CNT_W'(1)));
    assign it_mode = (state_q == ST_IDLE) ? op_mode(op_in) : op_mode(op_q);

    // FSM next state: accept in IDLE, iterate in CALC, hold result in DONE.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = op_in;
                    word_d = word_in;
                    sa_d   = sa_in;
                    sb_d   = sb_in;
                    cnt_d  = '0;
                    if (special) begin
                        state_d     = ST_DONE;
                        result_d    = special_res;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (kill_w) begin
                    state_d = ST_IDLE;
                end else if (last) begin
                    state_d     = ST_DONE;
                    result_d    = calc_res;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (kill_w || out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            word_q      <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    pippo_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && !special),
        .step   (state_q == ST_CALC),
        .mode   (it_mode),
        .n      (n_in),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .prod   (it_prod),
        .quo    (it_quo),
        .rem    (it_rem)
    );

    assign in_ready  = (state_q == ST_IDLE) && !kill_w;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_pippo_muldiv.sv
// Scoreboard bench for pippo_muldiv (WIDTH=64, RV64 with W variants).
// Stimulus pushes expected results and latencies; a monitor pops and
// compares whenever the unit presents a result.
module tb_pippo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        word;
    logic [63:0] bus_a;
    logic [63:0] bus_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    typedef struct {
        string       name;
        logic [63:0] res;
        int          lat;
        int          acceptCycle;
    } exp_t;

    exp_t expQ[$];
    int   checkCnt = 0;
    int   passCnt  = 0;
    int   cycleCnt = 0;
    bit   stallReq = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    pippo_muldiv #(
        .WIDTH (64),
        .CNT_W (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPPO_MULDIV_KILL_EN
        .kill      (1'b0),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model straight from the M-extension rules.
    task automatic refModel(input logic [2:0] o, input logic w, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] res, output int lat);
        logic [31:0]        ua, ub, r32;
        logic signed [31:0] sa, sb;
        logic signed [63:0] sa64, sb64;
        logic [127:0]       pa, pb, pp;
        bit                 special;
        special = 0;
        res  = '0;
        ua   = a[31:0];
        ub   = b[31:0];
        sa   = a[31:0];
        sb   = b[31:0];
        sa64 = a;
        sb64 = b;
        if (w) begin
            r32 = '0;
            case (o)
                3'd0: r32 = ua * ub;
                3'd1, 3'd2, 3'd3: begin r32 = '0; special = 1; end
                3'd4: begin
                    if (ub == 0) begin r32 = '1; special = 1; end
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin r32 = ua; special = 1; end
                    else r32 = sa / sb;
                end
                3'd5: begin
                    if (ub == 0) begin r32 = '1; special = 1; end
                    else r32 = ua / ub;
                end
                3'd6: begin
                    if (ub == 0) begin r32 = ua; special = 1; end
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin r32 = '0; special = 1; end
                    else r32 = sa % sb;
                end
                default: begin
                    if (ub == 0) begin r32 = ua; special = 1; end
                    else r32 = ua % ub;
                end
            endcase
            res = {{32{r32[31]}}, r32};
            lat = special ? 1 : 33;
        end else begin
            case (o)
                3'd0: res = a * b;
                3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pp = pa * pb; res = pp[127:64]; end
                3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       pp = pa * pb; res = pp[127:64]; end
                3'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       pp = pa * pb; res = pp[127:64]; end
                3'd4: begin
                    if (b == 0) begin res = '1; special = 1; end
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = a; special = 1; end
                    else res = sa64 / sb64;
                end
                3'd5: begin
                    if (b == 0) begin res = '1; special = 1; end
                    else res = a / b;
                end
                3'd6: begin
                    if (b == 0) begin res = a; special = 1; end
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = '0; special = 1; end
                    else res = sa64 % sb64;
                end
                default: begin
                    if (b == 0) begin res = a; special = 1; end
                    else res = a % b;
                end
            endcase
            lat = special ? 1 : 65;
        end
    endtask

    // Issue one op, wait (bounded) for acceptance, push the expectation,
    // then scramble the operand buses to show they are not re-sampled.
    task automatic applyStimulus(input string name, input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] expRes, input int expLat);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        op       = o;
        word     = w;
        bus_a    = a;
        bus_b    = b;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkCnt++;
            $display("[TB] FAIL accept_timeout %s: in_ready stayed %b, required 1", name, in_ready);
        end else begin
            e.name        = name;
            e.res         = expRes;
            e.lat         = expLat;
            e.acceptCycle = cycleCnt;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bus_a    = {$urandom, $urandom};
        bus_b    = {$urandom, $urandom};
        op       = 3'($urandom_range(0, 7));
    endtask

    task automatic applyRandom();
        logic [2:0]  o;
        logic        w;
        logic [63:0] a, b, r;
        int          lat;
        o = 3'($urandom_range(0, 7));
        w = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: b = '0;
            1: b = '1;
            2: a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
            3: b = 64'($urandom_range(1, 15));
            4: begin a = 64'($urandom_range(0, 1000)); b = {32'd0, $urandom}; end
            default: ;
        endcase
        refModel(o, w, a, b, r, lat);
        applyStimulus("rand", o, w, a, b, r, lat);
    endtask

    // Consumer back-pressure: random, or held low on request.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stallReq ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first out_valid, stability while stalled,
    // and result comparison on each output handshake.
    initial begin : monitor
        bit          seen;
        bit          prevStall;
        int          stallCnt;
        logic [63:0] prevRes;
        exp_t        e;
        seen      = 0;
        prevStall = 0;
        stallCnt  = 0;
        prevRes   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen      = 0;
                prevStall = 0;
            end else begin
                if (out_valid && !seen) begin
                    seen = 1;
                    if (expQ.size() == 0) begin
                        checkCnt++;
                        $display("[TB] FAIL unexpected_out: out_valid=1 with result %h, none expected", result);
                    end else begin
                        checkOutput({expQ[0].name, "_latency"}, 64'(cycleCnt - expQ[0].acceptCycle),
                                    64'(expQ[0].lat));
                    end
                end
                if (prevStall) begin
                    checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
                    checkOutput("hold_result", result, prevRes);
                    checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
                end
                if (stallReq && out_valid) begin
                    stallCnt++;
                    if (stallCnt >= 6) begin
                        stallReq = 0;
                        stallCnt = 0;
                    end
                end
                prevStall = out_valid && !out_ready;
                prevRes   = result;
                if (out_valid && out_ready && expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput(e.name, result, e.res);
                    seen = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int waitCnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'd0;
        word     = 1'b0;
        bus_a    = '0;
        bus_b    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed cases");
        stallReq = 1;
        applyStimulus("mulw_neg",     3'd0, 1'b1, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33);
        applyStimulus("mulhu_ones",   3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        applyStimulus("mulhsu_neg",   3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        applyStimulus("divw_ovf",     3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        applyStimulus("divuw_zero",   3'd5, 1'b1, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        applyStimulus("remw_zero",    3'd6, 1'b1, 64'd5, 64'd0, 64'd5, 1);
        applyStimulus("remw_neg",     3'd6, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        applyStimulus("divw_neg",     3'd4, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        applyStimulus("divw_upper",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33);
        applyStimulus("mul64",        3'd0, 1'b0, 64'h0000_0100_0000_0000, 64'd3, 64'h0000_0300_0000_0000, 65);
        applyStimulus("div64_ovf",    3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        applyStimulus("rem64_ovf",    3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        applyStimulus("mulhw_bad",    3'd1, 1'b1, 64'd123, 64'd456, 64'd0, 1);
        applyStimulus("divu64",       3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        applyStimulus("remu64",       3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        $display("[TB] reset during CALC");
        @(negedge clk);
        op       = 3'd0;
        word     = 1'b0;
        bus_a    = 64'd11;
        bus_b    = 64'd13;
        in_valid = 1'b1;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("calc_busy", {63'd0, busy}, 64'd1);
        checkOutput("calc_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);

        $display("[TB] random cases");
        for (int i = 0; i < 40; i++) begin
            applyRandom();
        end

        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 2000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (expQ.size() != 0) begin
            checkCnt++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", expQ.size());
        end
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
